// File: rtl/wordcell_arbiter_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : wordcell_arbiter_ctrl                                          |
// | Brief   : Round-robin two-port arbiter and setup/access/hold sequencer   |
// |           for a bank of 8-bit NAND-latch wordcells.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module wordcell_arbiter_ctrl #(
    parameter int WORDS         = 4,
    parameter int ADDR_W        = 2,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              busy,
    output logic              cell_op,
    output logic [WORDS-1:0]  cell_sel,
    output logic [7:0]        cell_in_bus,
    input  logic [7:0]        cell_out_bus
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_setup  = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_hold   = 2'd3;

    localparam int unsigned   c_words    = WORDS;
    localparam int            c_cnt_w    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(ACCESS_CYCLES - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last_grant;   // 0 = A, 1 = B
    logic               r_gnt_b;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_oor;
    logic               r_a_ack;
    logic               r_b_ack;
    logic               r_err;
    logic               r_busy;
    logic               r_cell_op;
    logic [WORDS-1:0]   r_cell_sel;
    logic [7:0]         r_cell_in_bus;
    logic [7:0]         r_rdata;

    logic               w_gnt_b;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [7:0]         w_wdata;
    logic               w_oor;
    logic [WORDS-1:0]   w_onehot;

    // On a tie the requester not served last time wins.
    assign w_gnt_b = b_req && (!a_req || !r_last_grant);
    assign w_we    = w_gnt_b ? b_we    : a_we;
    assign w_addr  = w_gnt_b ? b_addr  : a_addr;
    assign w_wdata = w_gnt_b ? b_wdata : a_wdata;
    assign w_oor   = (32'(w_addr) >= c_words);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_sel
            localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(gi);
            assign w_onehot[gi] = !r_oor && (r_addr == c_idx);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_last_grant  <= 1'b1;
            r_gnt_b       <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_oor         <= 1'b0;
            r_a_ack       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_cell_op     <= 1'b1;
            r_cell_sel    <= '0;
            r_cell_in_bus <= 8'h00;
            r_rdata       <= 8'h00;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (a_req || b_req) begin
                        r_gnt_b       <= w_gnt_b;
                        r_last_grant  <= w_gnt_b;
                        r_we          <= w_we;
                        r_addr        <= w_addr;
                        r_oor         <= w_oor;
                        r_cell_op     <= ~w_we;
                        r_cell_in_bus <= w_we ? w_wdata : 8'h00;
                        r_busy        <= 1'b1;
                        r_state       <= c_setup;
                    end
                end
                c_setup: begin
                    r_cell_sel <= w_onehot;
                    r_cnt      <= c_cnt_load;
                    r_state    <= c_access;
                end
                c_access: begin
                    if (r_cnt == '0) begin
                        r_cell_sel <= '0;
                        r_rdata    <= (!r_we && !r_oor) ? cell_out_bus : 8'h00;
                        r_a_ack    <= !r_gnt_b;
                        r_b_ack    <= r_gnt_b;
                        r_err      <= r_oor;
                        r_state    <= c_hold;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_hold: begin
                    // sel already dropped last edge, so op/in_bus may now change.
                    r_cell_op     <= 1'b1;
                    r_cell_in_bus <= 8'h00;
                    r_busy        <= 1'b0;
                    r_state       <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign busy        = r_busy;
    assign cell_op     = r_cell_op;
    assign cell_sel    = r_cell_sel;
    assign cell_in_bus = r_cell_in_bus;

endmodule

`default_nettype wire
